// File: rtl/mcpu_seq_if.sv
// Sequencer-side bundle: run/class/memory-handshake inputs, stage enables, status and counters.
// The sequencer takes the master view; decode, memory and the datapath see the slave view.
interface mcpu_seq_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic             is_mem;
    logic             is_load;
    logic             no_wb;
    logic             mem_ready;
    logic             clr_cnt;
    logic             mem_req;
    logic             IF_signal;
    logic             ID_signal;
    logic             EX_signal;
    logic             MEM_signal;
    logic             WB_signal;
    logic             IorD_signal;
    logic             IRWr;
    logic             PCWr;
    logic             retire;
    logic             timeout_err;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  run, is_mem, is_load, no_wb, mem_ready, clr_cnt,
        output mem_req, IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal,
               IorD_signal, IRWr, PCWr, retire, timeout_err, state, instr_cnt, stall_cnt
    );

    modport slave (
        output run, is_mem, is_load, no_wb, mem_ready, clr_cnt,
        input  mem_req, IF_signal, ID_signal, EX_signal, MEM_signal, WB_signal,
               IorD_signal, IRWr, PCWr, retire, timeout_err, state, instr_cnt, stall_cnt
    );
endinterface

// File: rtl/mcpu_seq.sv
// Multi-cycle sequencer for the mcpu core: ready-based memory waits, per-class stage
// skipping, run/halt at instruction boundaries, sticky access timeout and event counters.
//
// state | meaning
// IDLE  | halted, waiting for run
// IF    | instruction fetch, waits for mem_ready
// ID    | decode
// EX    | execute, commit next PC
// MEM   | data access, waits for mem_ready
// WB    | register write-back
// ERR   | memory timeout, left only by reset
module mcpu_seq #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input logic        i_clk,
    input logic        i_rst_n,
    mcpu_seq_if.master io_bus
);
    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_ERR  = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;
    state_t            w_after;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_mem_phase;
    logic              w_stall;
    logic              w_timeout;
    logic              w_irwr;
    logic              w_retire;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_irwr      = 1'b0;
        w_retire    = 1'b0;
        w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);
        w_stall     = w_mem_phase && !io_bus.mem_ready;
        w_timeout   = w_stall && (r_wait == '0);
        w_after     = io_bus.run ? S_IF : S_IDLE;
        case (r_state)
            S_IDLE: if (io_bus.run) w_next = S_IF;
            S_IF: begin
                if (io_bus.mem_ready) begin
                    w_irwr = 1'b1;
                    w_next = S_ID;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_ID: w_next = S_EX;
            S_EX: begin
                if (io_bus.is_mem) begin
                    w_next = S_MEM;
                end else if (io_bus.no_wb) begin
                    w_retire = 1'b1;
                    w_next   = w_after;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (io_bus.mem_ready) begin
                    if (io_bus.is_load) begin
                        w_irwr = 1'b1;
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = w_after;
                    end
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = w_after;
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // Down-counts wait cycles of the current access; reloaded whenever no wait is in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait <= WAIT_LOAD;
        end else if (w_stall) begin
            r_wait <= r_wait - 1'b1;
        end else begin
            r_wait <= WAIT_LOAD;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (io_bus.clr_cnt) begin
            r_instr_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign io_bus.mem_req     = w_mem_phase;
    assign io_bus.IF_signal   = (r_state == S_IF);
    assign io_bus.ID_signal   = (r_state == S_ID);
    assign io_bus.EX_signal   = (r_state == S_EX);
    assign io_bus.MEM_signal  = (r_state == S_MEM);
    assign io_bus.WB_signal   = (r_state == S_WB);
    assign io_bus.IorD_signal = (r_state == S_MEM);
    assign io_bus.PCWr        = (r_state == S_EX);
    assign io_bus.IRWr        = w_irwr;
    assign io_bus.retire      = w_retire;
    assign io_bus.timeout_err = (r_state == S_ERR);
    assign io_bus.state       = r_state;
    assign io_bus.instr_cnt   = r_instr_cnt;
    assign io_bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_mcpu_seq.sv
// Bench for mcpu_seq: per-instruction expected cycle traces are built from the class rules
// and wait schedule, then compared cycle by cycle along with modelled counters.
module tb_mcpu_seq;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int ST_IDLE = 0, ST_IF = 1, ST_ID = 2, ST_EX = 3, ST_MEM = 4, ST_WB = 5, ST_ERR = 7;
    localparam int C_ALU = 0, C_BR = 1, C_ST = 2, C_LD = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_instr = 0;
    int   exp_stall = 0;

    int          e_st[$];
    int          e_rdy[$];
    bit          e_ret[$];
    logic [13:0] e_vec[$];
    logic [13:0] o_vec[$];

    always #5 clk = ~clk;

    mcpu_seq_if #(.CNT_W(CNT_W)) bus ();

    mcpu_seq #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    // {state, WB..IF enables, mem_req, IorD, IRWr, PCWr, retire, timeout_err}
    function automatic logic [13:0] exp_vec(input int st, input bit irwr, input bit ret);
        logic [4:0] en = 5'd0;
        if (st >= ST_IF && st <= ST_WB) en = 5'(1 << (st - 1));
        return {3'(st), en, (st == ST_IF) || (st == ST_MEM), st == ST_MEM, irwr, st == ST_EX, ret,
                st == ST_ERR};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {bus.state, bus.WB_signal, bus.MEM_signal, bus.EX_signal, bus.ID_signal,
                bus.IF_signal, bus.mem_req, bus.IorD_signal, bus.IRWr, bus.PCWr, bus.retire,
                bus.timeout_err};
    endfunction

    task automatic add(input int st, input int rdy, input bit irwr, input bit ret);
        e_st.push_back(st);
        e_rdy.push_back(rdy);
        e_ret.push_back(ret);
        e_vec.push_back(exp_vec(st, irwr, ret));
    endtask

    // Reference trace for one instruction; rdy 2 means mem_ready is a don't-care that cycle.
    task automatic plan(input int cls, input int if_w, input int mem_w);
        e_st.delete(); e_rdy.delete(); e_ret.delete(); e_vec.delete();
        for (int i = 0; i <= if_w; i++) add(ST_IF, int'(i == if_w), i == if_w, 1'b0);
        add(ST_ID, 2, 1'b0, 1'b0);
        add(ST_EX, 2, 1'b0, cls == C_BR);
        if (cls == C_ST || cls == C_LD)
            for (int i = 0; i <= mem_w; i++)
                add(ST_MEM, int'(i == mem_w), (i == mem_w) && (cls == C_LD), (i == mem_w) && (cls == C_ST));
        if (cls == C_ALU || cls == C_LD) add(ST_WB, 2, 1'b0, 1'b1);
    endtask

    // Drives the planned trace, records what the DUT shows, and advances the counter model.
    task automatic exec(input int cls, input bit run_final, input bit clr_on_ret);
        o_vec.delete();
        for (int i = 0; i < e_st.size(); i++) begin
            @(negedge clk);
            bus.run = (e_st[i] >= ST_EX) ? run_final : 1'b1;
            if (e_st[i] == ST_EX || e_st[i] == ST_MEM) begin
                bus.is_mem  = (cls == C_ST) || (cls == C_LD);
                bus.is_load = (cls == C_LD) ? 1'b1 : (cls == C_ST) ? 1'b0 : 1'($urandom);
                bus.no_wb   = (cls == C_BR) ? 1'b1 : (cls == C_ALU) ? 1'b0 : 1'($urandom);
            end else begin
                bus.is_mem  = 1'($urandom);
                bus.is_load = 1'($urandom);
                bus.no_wb   = 1'($urandom);
            end
            bus.mem_ready = (e_rdy[i] == 2) ? 1'($urandom) : 1'(e_rdy[i]);
            bus.clr_cnt   = clr_on_ret && e_ret[i];
            #1;
            o_vec.push_back(obs_vec());
            exp_instr = (exp_instr + int'(e_ret[i])) % (CMAX + 1);
            if ((e_st[i] == ST_IF || e_st[i] == ST_MEM) && e_rdy[i] == 0 && exp_stall < CMAX)
                exp_stall++;
            if (bus.clr_cnt) begin
                exp_instr = 0;
                exp_stall = 0;
            end
        end
        @(posedge clk);
        #1;
        bus.clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        bus.run = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 14'd0) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), 14'd0);
        end
        checks++;
        if (bus.instr_cnt !== '0 || bus.stall_cnt !== '0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", bus.instr_cnt, bus.stall_cnt);
        end
        @(negedge clk);
        bus.run = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obs_vec() !== exp_vec(ST_IDLE, 0, 0)) begin
            errors++; $display("FAIL reset_idle_hold: got %b expected %b", obs_vec(), exp_vec(ST_IDLE, 0, 0));
        end
    endtask

    task automatic test_alu_stream();
        @(negedge clk);
        bus.run = 1'b1;
        for (int n = 0; n < 3; n++) begin
            plan(C_ALU, 0, 0);
            exec(C_ALU, 1'b1, 1'b0);
            for (int i = 0; i < e_vec.size(); i++) begin
                checks++;
                if (o_vec[i] !== e_vec[i]) begin
                    errors++; $display("FAIL alu_stream n%0d cyc%0d: got %b expected %b", n, i, o_vec[i], e_vec[i]);
                end
            end
        end
        checks++;
        if (bus.instr_cnt !== CNT_W'(exp_instr) || bus.stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL alu_counters: got %0d/%0d expected %0d/%0d", bus.instr_cnt, bus.stall_cnt, exp_instr, exp_stall);
        end
    endtask

    task automatic test_load_waits();
        plan(C_LD, 2, 3);
        exec(C_LD, 1'b1, 1'b0);
        for (int i = 0; i < e_vec.size(); i++) begin
            checks++;
            if (o_vec[i] !== e_vec[i]) begin
                errors++; $display("FAIL load_waits cyc%0d: got %b expected %b", i, o_vec[i], e_vec[i]);
            end
        end
        checks++;
        if (bus.stall_cnt !== CNT_W'(exp_stall) || bus.instr_cnt !== CNT_W'(exp_instr)) begin
            errors++; $display("FAIL load_counters: got %0d/%0d expected %0d/%0d", bus.stall_cnt, bus.instr_cnt, exp_stall, exp_instr);
        end
    endtask

    task automatic test_branch_store();
        int cls_list[2] = '{C_BR, C_ST};
        foreach (cls_list[k]) begin
            plan(cls_list[k], 0, 0);
            exec(cls_list[k], 1'b1, 1'b0);
            for (int i = 0; i < e_vec.size(); i++) begin
                checks++;
                if (o_vec[i] !== e_vec[i]) begin
                    errors++; $display("FAIL branch_store cls%0d cyc%0d: got %b expected %b", cls_list[k], i, o_vec[i], e_vec[i]);
                end
            end
        end
    endtask

    task automatic test_run_drop();
        plan(C_ALU, 1, 0);
        exec(C_ALU, 1'b0, 1'b0);
        for (int i = 0; i < e_vec.size(); i++) begin
            checks++;
            if (o_vec[i] !== e_vec[i]) begin
                errors++; $display("FAIL run_drop cyc%0d: got %b expected %b", i, o_vec[i], e_vec[i]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom);
            #1;
            checks++;
            if (obs_vec() !== exp_vec(ST_IDLE, 0, 0)) begin
                errors++; $display("FAIL run_drop_idle%0d: got %b expected %b", k, obs_vec(), exp_vec(ST_IDLE, 0, 0));
            end
        end
        bus.run = 1'b1;
        plan(C_ALU, 0, 0);
        exec(C_ALU, 1'b1, 1'b0);
        for (int i = 0; i < e_vec.size(); i++) begin
            checks++;
            if (o_vec[i] !== e_vec[i]) begin
                errors++; $display("FAIL run_resume cyc%0d: got %b expected %b", i, o_vec[i], e_vec[i]);
            end
        end
    endtask

    task automatic test_timeout_boundary();
        plan(C_LD, TIMEOUT - 1, TIMEOUT - 1);
        exec(C_LD, 1'b1, 1'b0);
        for (int i = 0; i < e_vec.size(); i++) begin
            checks++;
            if (o_vec[i] !== e_vec[i]) begin
                errors++; $display("FAIL timeout_boundary cyc%0d: got %b expected %b", i, o_vec[i], e_vec[i]);
            end
        end
        checks++;
        if (bus.stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL stall_saturate: got %0d expected %0d", bus.stall_cnt, exp_stall);
        end
    endtask

    task automatic test_wrap_clr();
        plan(C_BR, 0, 0);
        exec(C_BR, 1'b1, 1'b1);
        checks++;
        if (bus.instr_cnt !== CNT_W'(exp_instr) || bus.stall_cnt !== CNT_W'(exp_stall)) begin
            errors++; $display("FAIL clr_on_retire: got %0d/%0d expected %0d/%0d", bus.instr_cnt, bus.stall_cnt, exp_instr, exp_stall);
        end
        for (int n = 0; n < CMAX + 1; n++) begin
            plan(C_BR, 0, 0);
            exec(C_BR, 1'b1, 1'b0);
            if (n == CMAX - 1 || n == CMAX) begin
                checks++;
                if (bus.instr_cnt !== CNT_W'(exp_instr)) begin
                    errors++; $display("FAIL instr_wrap n%0d: got %0d expected %0d", n, bus.instr_cnt, exp_instr);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int cls    = $urandom_range(3, 0);
            bit runf   = ($urandom_range(9, 0) != 0);
            bit clr    = ($urandom_range(9, 0) == 0);
            plan(cls, $urandom_range(4, 0), $urandom_range(4, 0));
            exec(cls, runf, clr);
            for (int i = 0; i < e_vec.size(); i++) begin
                checks++;
                if (o_vec[i] !== e_vec[i]) begin
                    errors++; $display("FAIL random n%0d cls%0d cyc%0d: got %b expected %b", n, cls, i, o_vec[i], e_vec[i]);
                end
            end
            checks++;
            if (bus.instr_cnt !== CNT_W'(exp_instr) || bus.stall_cnt !== CNT_W'(exp_stall)) begin
                errors++; $display("FAIL random_counters n%0d: got %0d/%0d expected %0d/%0d", n, bus.instr_cnt, bus.stall_cnt, exp_instr, exp_stall);
            end
            if (!runf) begin
                @(negedge clk);
                #1;
                checks++;
                if (obs_vec() !== exp_vec(ST_IDLE, 0, 0)) begin
                    errors++; $display("FAIL random_idle n%0d: got %b expected %b", n, obs_vec(), exp_vec(ST_IDLE, 0, 0));
                end
                bus.run = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        plan(C_ST, 0, 3);
        while (e_st.size() > 5) begin
            void'(e_st.pop_back()); void'(e_rdy.pop_back()); void'(e_ret.pop_back()); void'(e_vec.pop_back());
        end
        exec(C_ST, 1'b1, 1'b0);
        for (int i = 0; i < e_vec.size(); i++) begin
            checks++;
            if (o_vec[i] !== e_vec[i]) begin
                errors++; $display("FAIL mid_mem_prefix cyc%0d: got %b expected %b", i, o_vec[i], e_vec[i]);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 14'd0 || bus.instr_cnt !== '0 || bus.stall_cnt !== '0) begin
            errors++; $display("FAIL reset_mid_mem: got %b cnt %0d/%0d expected all zero", obs_vec(), bus.instr_cnt, bus.stall_cnt);
        end
        exp_instr = 0;
        exp_stall = 0;
        @(negedge clk);
        bus.run = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_timeout_err();
        @(negedge clk);
        bus.run = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (obs_vec() !== exp_vec(ST_IF, 0, 0)) begin
                errors++; $display("FAIL timeout_wait%0d: got %b expected %b", k, obs_vec(), exp_vec(ST_IF, 0, 0));
            end
            if (exp_stall < CMAX) exp_stall++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom);
            bus.run       = 1'($urandom);
            #1;
            checks++;
            if (obs_vec() !== exp_vec(ST_ERR, 0, 0)) begin
                errors++; $display("FAIL timeout_err_hold%0d: got %b expected %b", k, obs_vec(), exp_vec(ST_ERR, 0, 0));
            end
        end
        checks++;
        if (bus.stall_cnt !== CNT_W'(exp_stall) || bus.instr_cnt !== CNT_W'(exp_instr)) begin
            errors++; $display("FAIL timeout_counters: got %0d/%0d expected %0d/%0d", bus.stall_cnt, bus.instr_cnt, exp_stall, exp_instr);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_vec() !== 14'd0) begin
            errors++; $display("FAIL err_reset: got %b expected %b", obs_vec(), 14'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of tests");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.run = 1'b0; bus.is_mem = 1'b0; bus.is_load = 1'b0; bus.no_wb = 1'b0;
        bus.mem_ready = 1'b0; bus.clr_cnt = 1'b0;
        #2 rst_n = 1'b0;
        test_reset();
        test_alu_stream();
        test_load_waits();
        test_branch_store();
        test_run_drop();
        test_timeout_boundary();
        test_wrap_clr();
        test_random();
        test_reset_mid_mem();
        test_timeout_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
